// File: rtl/max_search_ctrl_if.sv
// ---------------------------------------------------------------------------
// max_search_ctrl_if
// Stream and result bundle for the sequential maximum finder.
//   start      : begin a burst (sampled only while the block is idle)
//   len        : burst length, sampled with start
//   din_valid  : din holds a word
//   din        : 4-bit unsigned data word
//   din_ready  : block accepts din this cycle
//   busy       : block is not idle
//   done_tick  : one-cycle pulse, results are final
//   max        : largest word of the last burst
//   max_idx    : 0-based position of the first occurrence of max
//   empty      : last burst had len == 0
// master = burst source / result consumer, slave = max_search_ctrl.
// ---------------------------------------------------------------------------
interface max_search_ctrl_if #(
    parameter int LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             din_valid;
    logic [3:0]       din;
    logic             din_ready;
    logic             busy;
    logic             done_tick;
    logic [3:0]       max;
    logic [LEN_W-1:0] max_idx;
    logic             empty;

    modport master (
        output start, len, din_valid, din,
        input  din_ready, busy, done_tick, max, max_idx, empty
    );

    modport slave (
        input  start, len, din_valid, din,
        output din_ready, busy, done_tick, max, max_idx, empty
    );
endinterface

// File: rtl/max_search_ctrl.sv
// ---------------------------------------------------------------------------
// max_search_ctrl
// Sequential maximum finder. Accepts a burst of len 4-bit words over a
// valid/ready stream, feeding the 4-bit greater-than comparator one operand
// pair per cycle, and keeps a running maximum and its index. Results are
// reported with a one-cycle done_tick.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : max_search_ctrl_if.slave (stream in, results out)
// ---------------------------------------------------------------------------

// 4-bit unsigned strict greater-than comparator: gt = (i1 > i0).
module greater_than_4b (
    input  logic [3:0] i1,
    input  logic [3:0] i0,
    output logic       gt
);
    assign gt = (i1 > i0);
endmodule

module max_search_ctrl #(
    parameter int LEN_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    max_search_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, FIRST, CMP, DONE} state_t;

    localparam logic [LEN_W-1:0] ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [3:0]       max_q, max_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             empty_q, empty_d;

    logic             gt;
    logic             din_ready;
    logic             xfer;
    logic [LEN_W-1:0] cnt_inc;

    greater_than_4b u_gt (
        .i1 (bus.din),
        .i0 (max_q),
        .gt (gt)
    );

    // Moore ready: never looks at din_valid.
    assign din_ready = (state_q == FIRST) || (state_q == CMP);
    assign xfer      = bus.din_valid & din_ready;
    // cnt_q stays below len_q inside a burst, so this never wraps.
    assign cnt_inc   = cnt_q + ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            max_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            empty_q <= empty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        empty_d = empty_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != ZERO) begin
                        len_d   = bus.len;
                        cnt_d   = ZERO;
                        empty_d = 1'b0;
                        state_d = FIRST;
                    end else begin
                        // Empty burst: report immediately with cleared results.
                        empty_d = 1'b1;
                        max_d   = 4'd0;
                        idx_d   = ZERO;
                        state_d = DONE;
                    end
                end
            end
            FIRST: begin
                if (xfer) begin
                    max_d   = bus.din;
                    idx_d   = ZERO;
                    cnt_d   = ONE;
                    state_d = (len_q == ONE) ? DONE : CMP;
                end
            end
            CMP: begin
                if (xfer) begin
                    // Strict compare: ties keep the first occurrence.
                    if (gt) begin
                        max_d = bus.din;
                        idx_d = cnt_q;
                    end
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.din_ready = din_ready;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done_tick = (state_q == DONE);
    assign bus.max       = max_q;
    assign bus.max_idx   = idx_q;
    assign bus.empty     = empty_q;
endmodule
